timestamp_fifo_arbiter: RTL and testbench

- Round-robin, packet-atomic arbiter that merges up to N_SRC timestamp_core-style 32-bit FIFO outputs into one FIFO-style stream for the readout/SiTCP path.
- Holds a grant for exactly PACKET_LEN consecutive words, so a 3-word timestamp record is never interleaved with words from another source.
- Sits between the per-channel timestamp cores and the system readout FIFO.
- Inputs and output use first-word-fall-through semantics: DATA is valid while EMPTY=0, and READ pops.

---
 rtl/timestamp_fifo_arbiter.sv | 142 ++++++++++++++
 tb/tb_timestamp_fifo_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_fifo_arbiter.sv
// Packet-atomic round-robin merger for timestamp core FIFO outputs.
//
// Up to N_SRC first-word-fall-through source FIFOs are merged into one
// first-word-fall-through output stream. A grant is held for exactly
// PACKET_LEN words, so a multi-word timestamp record is never interleaved
// with words from another source. Words pass through bit-exact.
//
// Ports:
//   CLK, RST_N   single clock, asynchronous active-low reset
//   SRC_EN       per-source enable mask (sampled only while arbitrating)
//   SRC_EMPTY    source FIFO empty flags
//   SRC_DATA     source FIFO heads, source i at [i*DATA_W +: DATA_W]
//   SRC_READ     one-hot source pop strobe
//   FIFO_READ    downstream pop
//   FIFO_EMPTY   output register empty
//   FIFO_DATA    output word
//   FIFO_SRC     index of the source that produced FIFO_DATA
//   BUSY         high while a packet grant is held
module timestamp_fifo_arbiter #(
  parameter int N_SRC      = 4,
  parameter int PACKET_LEN = 3,
  parameter int DATA_W     = 32,
  localparam int IDX_W     = $clog2(N_SRC),
  localparam int CNT_W     = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_SRC-1:0]        SRC_EN,
  input  logic [N_SRC-1:0]        SRC_EMPTY,
  input  logic [N_SRC*DATA_W-1:0] SRC_DATA,
  output logic [N_SRC-1:0]        SRC_READ,
  input  logic                    FIFO_READ,
  output logic                    FIFO_EMPTY,
  output logic [DATA_W-1:0]       FIFO_DATA,
  output logic [IDX_W-1:0]        FIFO_SRC,
  output logic                    BUSY
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACKET_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   grant, grant_nxt;
  logic [IDX_W-1:0]   last_grant, last_grant_nxt;
  logic [CNT_W-1:0]   word_cnt, word_cnt_nxt;

  logic [N_SRC-1:0]   req;
  logic               found;
  logic [IDX_W-1:0]   pick;
  int                 rr_idx;
  logic               xfer;
  logic [DATA_W-1:0]  src_head;

  assign req      = SRC_EN & ~SRC_EMPTY;
  assign src_head = SRC_DATA[int'(grant)*DATA_W +: DATA_W];
  // A word moves only when the granted head is present and the output
  // register is free or being drained in the same cycle.
  assign xfer     = (state == GRANT) && !SRC_EMPTY[grant] && (FIFO_EMPTY || FIFO_READ);
  assign BUSY     = (state == GRANT);

  always_comb begin
    SRC_READ = '0;
    if (xfer) SRC_READ[grant] = 1'b1;
  end

  // Round-robin search starting just above the previous winner, wrapping
  // modulo N_SRC; the previous winner itself is checked last.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      rr_idx = int'(last_grant) + k;
      if (rr_idx >= N_SRC) rr_idx = rr_idx - N_SRC;
      if (!found && req[rr_idx]) begin
        found = 1'b1;
        pick  = IDX_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(N_SRC - 1);
      word_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      word_cnt   <= word_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    word_cnt_nxt   = word_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = GRANT;
          grant_nxt      = pick;
          last_grant_nxt = pick;
          word_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // An empty granted source simply stalls here; the packet is never
        // abandoned, and SRC_EN is not looked at until the packet ends.
        if (xfer) begin
          if (word_cnt == LAST_CNT) begin
            state_nxt    = IDLE;
            word_cnt_nxt = '0;
          end else begin
            word_cnt_nxt = word_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FIFO_EMPTY <= 1'b1;
      FIFO_DATA  <= '0;
      FIFO_SRC   <= '0;
    end else if (xfer) begin
      FIFO_DATA  <= src_head;
      FIFO_SRC   <= grant;
      FIFO_EMPTY <= 1'b0;
    end else if (FIFO_READ) begin
      FIFO_EMPTY <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timestamp_fifo_arbiter.sv
// Bench for timestamp_fifo_arbiter: source FIFOs are modelled as queues, a
// packet-level reference model predicts every output each cycle, and a
// vector table plus short directed sequences cover the corner cases.
module tb_timestamp_fifo_arbiter;
  localparam int N  = 4;
  localparam int PL = 3;
  localparam int W  = 32;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic [N-1:0]   src_en = '1;
  logic [N-1:0]   src_empty = '1;
  logic [N*W-1:0] src_data = '0;
  logic [N-1:0]   src_read;
  logic           fifo_read = 1'b0;
  logic           fifo_empty;
  logic [W-1:0]   fifo_data;
  logic [1:0]     fifo_src;
  logic           busy;

  // second instance: PACKET_LEN=1, every source permanently full
  logic [N-1:0]   src_read1;
  logic           fifo_empty1, busy1;
  logic [W-1:0]   fifo_data1;
  logic [1:0]     fifo_src1;
  logic [N*W-1:0] src_data1;
  assign src_data1 = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};

  always #5 CLK = ~CLK;

  timestamp_fifo_arbiter #(.N_SRC(N), .PACKET_LEN(PL), .DATA_W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .SRC_EN(src_en), .SRC_EMPTY(src_empty),
    .SRC_DATA(src_data), .SRC_READ(src_read), .FIFO_READ(fifo_read),
    .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data), .FIFO_SRC(fifo_src),
    .BUSY(busy));

  timestamp_fifo_arbiter #(.N_SRC(N), .PACKET_LEN(1), .DATA_W(W)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .SRC_EN(4'b1111), .SRC_EMPTY(4'b0000),
    .SRC_DATA(src_data1), .SRC_READ(src_read1), .FIFO_READ(1'b1),
    .FIFO_EMPTY(fifo_empty1), .FIFO_DATA(fifo_data1), .FIFO_SRC(fifo_src1),
    .BUSY(busy1));

  int checks = 0;
  int errors = 0;

  logic [W-1:0] srcq [N][$];
  int           got_src [$];
  logic [W-1:0] got_data [$];

  // reference model: packet owner, words left in packet, one-word output slot
  bit           m_busy;
  int           m_src, m_left, m_last;
  bit           m_ov;
  int           m_osrc;
  logic [W-1:0] m_odata;

  // snapshot of DUT outputs at the last sample point
  logic [N-1:0] s_rd;
  logic         s_emp, s_busy;
  logic [W-1:0] s_data;
  logic [1:0]   s_src;
  int           viol;

  typedef struct {
    logic         rd;
    logic [N-1:0] srd;
    logic         emp;
    logic [W-1:0] data;
    logic [1:0]   src;
    logic         bsy;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_src = 0; m_left = 0; m_last = N - 1;
    m_ov = 0; m_osrc = 0; m_odata = '0;
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      src_empty[i]      = (srcq[i].size() == 0);
      src_data[i*W +: W] = (srcq[i].size() != 0) ? srcq[i][0] : '0;
    end
  endtask

  task automatic tick();
    logic [N-1:0] exp_rd;
    logic [N-1:0] rd;
    bit           xf;
    drive_src();
    #1;
    xf = m_busy && (srcq[m_src].size() != 0) && (!m_ov || fifo_read);
    exp_rd = '0;
    if (xf) exp_rd[m_src] = 1'b1;
    s_rd = src_read; s_emp = fifo_empty; s_busy = busy; s_data = fifo_data; s_src = fifo_src;
    chk("src_read", src_read, exp_rd);
    chk("busy", busy, m_busy);
    chk("fifo_empty", fifo_empty, !m_ov);
    if (m_ov) begin
      chk("fifo_data", fifo_data, m_odata);
      chk("fifo_src", fifo_src, m_osrc);
    end
    if (!fifo_empty && !fifo_read && src_read != 0) viol++;
    if (!fifo_empty && fifo_read) begin
      got_src.push_back(int'(fifo_src));
      got_data.push_back(fifo_data);
    end
    rd = src_read;
    @(posedge CLK);
    if (m_ov && fifo_read) m_ov = 0;
    if (m_busy) begin
      if (xf) begin
        m_ov = 1; m_osrc = m_src; m_odata = srcq[m_src][0];
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (m_last + k) % N;
        if (src_en[s] && srcq[s].size() != 0) begin
          m_busy = 1; m_src = s; m_left = PL; m_last = s;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (rd[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    fifo_read = 1'b0;
    src_en = '1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive_src();
    m_reset();
    got_src.delete();
    got_data.delete();
    viol = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'b0000, 1'b1, 32'h0,        2'd0, 1'b0};
    tbl[1] = '{1'b1, 4'b0100, 1'b1, 32'h0,        2'd0, 1'b1};
    tbl[2] = '{1'b1, 4'b0100, 1'b0, 32'h11000001, 2'd2, 1'b1};
    tbl[3] = '{1'b1, 4'b0100, 1'b0, 32'h12000002, 2'd2, 1'b1};
    tbl[4] = '{1'b1, 4'b0000, 1'b0, 32'h13000003, 2'd2, 1'b0};
    tbl[5] = '{1'b1, 4'b0000, 1'b1, 32'h0,        2'd0, 1'b0};

    // reset values
    do_reset();
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_fifo_src", fifo_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src_read", src_read, 0);

    // single source, vector table
    do_reset();
    srcq[2].push_back(32'h11000001);
    srcq[2].push_back(32'h12000002);
    srcq[2].push_back(32'h13000003);
    for (int i = 0; i < 6; i++) begin
      fifo_read = tbl[i].rd;
      tick();
      chk($sformatf("tbl%0d_src_read", i), s_rd, tbl[i].srd);
      chk($sformatf("tbl%0d_empty", i), s_emp, tbl[i].emp);
      chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].bsy);
      if (!tbl[i].emp) begin
        chk($sformatf("tbl%0d_data", i), s_data, tbl[i].data);
        chk($sformatf("tbl%0d_src", i), s_src, tbl[i].src);
      end
    end

    // reset in the middle of a packet
    do_reset();
    for (int j = 1; j <= 3; j++) srcq[0].push_back(32'hA0000000 + j);
    fifo_read = 1'b1;
    tick();
    tick();
    RST_N = 1'b0;
    #1;
    chk("midrst_empty", fifo_empty, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_src_read", src_read, 0);
    m_reset();
    got_src.delete();
    got_data.delete();
    #1;
    RST_N = 1'b1;
    repeat (3) tick();
    chk("midrst_words", got_data.size(), 1);
    if (got_data.size() > 0) chk("midrst_restart_word", got_data[0], 32'hA0000002);

    // round-robin over two packets per source
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2*PL; j++) srcq[i].push_back(32'hC0000000 | (i << 8) | j);
    fifo_read = 1'b1;
    repeat (40) tick();
    chk("rr_words", got_data.size(), 2*N*PL);
    for (int w = 0; w < got_data.size() && w < 2*N*PL; w++) begin
      int p;
      p = w / PL;
      chk($sformatf("rr_src%0d", w), got_src[w], p % N);
      chk($sformatf("rr_data%0d", w), got_data[w],
          32'hC0000000 | ((p % N) << 8) | ((p / N) * PL + w % PL));
    end

    // starvation hold: source 1 stalls mid-packet while source 3 is full
    do_reset();
    srcq[1].push_back(32'hB1000001);
    for (int j = 0; j < PL; j++) srcq[3].push_back(32'hB3000000 + j);
    fifo_read = 1'b1;
    repeat (22) tick();
    chk("hold_words", got_data.size(), 1);
    chk("hold_src3_untouched", srcq[3].size(), PL);
    srcq[1].push_back(32'hB1000002);
    srcq[1].push_back(32'hB1000003);
    repeat (15) tick();
    chk("hold_total", got_data.size(), 2*PL);
    for (int w = 0; w < got_src.size() && w < 2*PL; w++)
      chk($sformatf("hold_src%0d", w), got_src[w], (w < PL) ? 1 : 3);

    // enable mask: source 3 disabled
    do_reset();
    src_en = 4'b0111;
    for (int j = 0; j < 2*PL; j++) srcq[3].push_back(32'hE3000000 + j);
    for (int j = 0; j < PL; j++) srcq[0].push_back(32'hE0000000 + j);
    fifo_read = 1'b1;
    repeat (20) tick();
    chk("mask_words", got_data.size(), PL);
    chk("mask_src3_untouched", srcq[3].size(), 2*PL);

    // back-pressure: downstream reads 1,0,0,...
    do_reset();
    for (int j = 0; j < 2*PL; j++) begin
      srcq[0].push_back(32'hF0000000 + j);
      srcq[2].push_back(32'hF2000000 + j);
    end
    for (int c = 0; c < 80; c++) begin
      fifo_read = (c % 3 == 0);
      tick();
    end
    chk("bp_words", got_data.size(), 4*PL);
    chk("bp_read_while_full", viol, 0);
    for (int w = 0; w < got_data.size() && w < 4*PL; w++) begin
      int p;
      p = w / PL;
      chk($sformatf("bp_data%0d", w), got_data[w],
          ((p % 2 == 0) ? 32'hF0000000 : 32'hF2000000) + (p / 2) * PL + w % PL);
    end

    // wrap from last_grant=3 to source 0
    do_reset();
    for (int j = 0; j < PL; j++) srcq[3].push_back(32'h93000000 + j);
    fifo_read = 1'b1;
    repeat (6) tick();
    for (int j = 0; j < PL; j++) srcq[0].push_back(32'h90000000 + j);
    repeat (6) tick();
    chk("wrap_words", got_src.size(), 2*PL);
    if (got_src.size() > PL) chk("wrap_grant0", got_src[PL], 0);

    // PACKET_LEN=1 instance: grants 0,1,2,3 every 2 cycles
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] e;
      #1;
      e = (i % 2 == 1) ? (4'b0001 << (i / 2)) : 4'b0000;
      chk($sformatf("pl1_src_read%0d", i), src_read1, e);
      if (i > 0 && i % 2 == 0) begin
        chk($sformatf("pl1_src%0d", i), fifo_src1, i/2 - 1);
        chk($sformatf("pl1_data%0d", i), fifo_data1, 32'hD0000000 + i/2 - 1);
      end
      @(posedge CLK);
      #1;
    end

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0 && srcq[i].size() < 10) srcq[i].push_back($urandom);
      fifo_read = ($urandom_range(2) != 0);
      if ($urandom_range(49) == 0) src_en = N'($urandom);
      tick();
    end
    chk("rand_read_while_full", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
